result_writer: RTL

- Downstream consumer of the 9-word result buffer.
- Accepts one 32-bit word per i_write_enable pulse and writes it to the output image memory over a simple request/ready write bus with wait states.
- Generates raster-ordered byte addresses and returns a one-cycle i_write_complete-compatible pulse per word.
- Flags frame completion, overrun and bus timeout, so the upstream buffer FSM never hangs.

---
 rtl/result_writer_pkg.sv | 14 +
 rtl/wr_addr_counter.sv | 43 ++++
 rtl/result_writer.sv | 107 ++++++++++
 3 files changed

// File: rtl/result_writer_pkg.sv
// Shared types and constants for the result writer.
//   state_t    : writer FSM states (IDLE, REQ, DONE)
//   WORD_BYTES : byte stride between consecutive output words
package result_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/wr_addr_counter.sv
// Raster-order write address generator.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   advance  : step to the next word (one pulse per finished word)
//   addr     : current byte address, BASE_ADDR after reset / after wrap
//   wrap     : high together with advance when the last word of a frame is stepped past
module wr_addr_counter
  import result_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        advance,
  output logic [31:0] addr,
  output logic        wrap
);

  localparam int unsigned   IW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

  logic [IW-1:0] index;

  // Combinational so the top can register it alongside the complete pulse.
  assign wrap = advance && (index == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= '0;
      addr  <= BASE_ADDR;
    end else if (advance) begin
      if (index == LAST) begin
        index <= '0;
        addr  <= BASE_ADDR;
      end else begin
        index <= index + IW'(1);
        addr  <= addr + WORD_BYTES;
      end
    end
  end

endmodule

// File: rtl/result_writer.sv
// Writes one 32-bit word per i_write_enable pulse to image memory over a
// request/ready bus, with bounded waiting so upstream never stalls forever.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_write_enable   : one-cycle write request, i_buffer_data valid same cycle
//   i_buffer_data    : word to write
//   i_mem_ready      : memory accepts the pending write this cycle
//   o_mem_addr       : byte write address (raster order, wraps per frame)
//   o_mem_wdata      : write data, stable while requesting
//   o_mem_write      : write request, held until accepted or timed out
//   o_write_complete : one-cycle pulse per finished word (accepted or aborted)
//   o_busy           : state other than IDLE
//   o_frame_done     : one-cycle pulse with the complete of a frame's last word
//   o_overrun        : sticky, write enable seen while busy
//   o_error          : sticky, a write timed out
module result_writer
  import result_writer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_write_enable,
  input  logic [31:0] i_buffer_data,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_write,
  output logic        o_write_complete,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun,
  output logic        o_error
);

  localparam int unsigned   TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  state_t        state;
  logic [TW-1:0] tcount;
  logic [TW-1:0] tcount_inc;
  logic          finish;
  logic          wrap;

  assign tcount_inc = tcount + TW'(1);
  // Leaving REQ either way (accepted or timed out) advances the raster position.
  assign finish     = (state == REQ) && (i_mem_ready || (tcount_inc == TLIM));
  assign o_busy     = (state != IDLE);

  wr_addr_counter #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_WORDS (NUM_WORDS)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .advance (finish),
    .addr    (o_mem_addr),
    .wrap    (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      tcount           <= '0;
      o_mem_wdata      <= '0;
      o_mem_write      <= 1'b0;
      o_write_complete <= 1'b0;
      o_frame_done     <= 1'b0;
      o_overrun        <= 1'b0;
      o_error          <= 1'b0;
    end else begin
      o_write_complete <= 1'b0;
      o_frame_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_write_enable) begin
            o_mem_wdata <= i_buffer_data;
            tcount      <= '0;
            o_mem_write <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (i_write_enable) o_overrun <= 1'b1;
          // Ready on the limit cycle wins over the timeout.
          if (finish) begin
            if (!i_mem_ready) o_error <= 1'b1;
            o_mem_write      <= 1'b0;
            o_write_complete <= 1'b1;
            o_frame_done     <= wrap;
            state            <= DONE;
          end else begin
            tcount <= tcount_inc;
          end
        end
        DONE: begin
          if (i_write_enable) o_overrun <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
